// File: rtl/program_counter_callstack.sv
// Fetch-stage program counter with a circular hardware call/return stack.
// Supports INC, JMP (absolute or PC-relative), CALL (push return address) and RET (pop).
module program_counter_callstack #(
    parameter int AW         = 10,
    parameter int STEP       = 2,
    parameter int DEPTH      = 16,
    parameter int RESET_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 op,
    input  logic                       rel,
    input  logic [AW-1:0]              din,
    input  logic                       clr_err,
    output logic [AW-1:0]              pc,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    logic [AW-1:0] stack_mem [DEPTH];
    logic [PW-1:0] top_ptr;
    logic [DW-1:0] depth_cnt;

    logic [AW-1:0] seq;
    logic [AW-1:0] tgt;
    logic [PW-1:0] top_prev;
    logic [AW-1:0] pc_next;
    logic [PW-1:0] ptr_next;
    logic [DW-1:0] depth_next;
    logic          push;
    logic          ovf_set;
    logic          unf_set;

    assign depth = depth_cnt;
    assign full  = (depth_cnt == DW'(DEPTH));
    assign empty = (depth_cnt == '0);

    // top_ptr addresses the next free slot; a push while full lands on the oldest entry
    always_comb begin
        seq        = pc + AW'(STEP);
        tgt        = rel ? (pc + din) : din;
        top_prev   = top_ptr - PW'(1);
        pc_next    = pc;
        ptr_next   = top_ptr;
        depth_next = depth_cnt;
        push       = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (en) begin
            case (op)
                OP_INC: pc_next = seq;
                OP_JMP: pc_next = tgt;
                OP_CALL: begin
                    push     = 1'b1;
                    ptr_next = top_ptr + PW'(1);
                    pc_next  = tgt;
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        depth_next = depth_cnt + DW'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_next = seq;
                        unf_set = 1'b1;
                    end else begin
                        pc_next    = stack_mem[top_prev];
                        ptr_next   = top_prev;
                        depth_next = depth_cnt - DW'(1);
                    end
                end
                default: pc_next = pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= AW'(RESET_ADDR);
            top_ptr   <= '0;
            depth_cnt <= '0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            pc        <= pc_next;
            top_ptr   <= ptr_next;
            depth_cnt <= depth_next;
            ovf_err   <= ovf_set | (ovf_err & ~clr_err);
            unf_err   <= unf_set | (unf_err & ~clr_err);
        end
    end

    // Stack storage needs no reset; contents are meaningless while depth is zero
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_mem[top_ptr] <= seq;
        end
    end

endmodule

// File: tb/tb_program_counter_callstack.sv
// Directed bench for program_counter_callstack: a queue-based reference model feeds
// a scoreboard of expected states that is popped and compared after each clock edge.
module tb_program_counter_callstack;

    localparam int AW    = 10;
    localparam int STEP  = 2;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH+1);

    logic          clk;
    logic          rst;
    logic          en;
    logic [1:0]    op;
    logic          rel;
    logic [AW-1:0] din;
    logic          clr_err;
    logic [AW-1:0] pc;
    logic [DW-1:0] depth;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          unf_err;

    program_counter_callstack #(
        .AW(AW), .STEP(STEP), .DEPTH(DEPTH), .RESET_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .rel(rel), .din(din),
        .clr_err(clr_err), .pc(pc), .depth(depth), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [AW-1:0] pc;
        int            depth;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          scoreboard[$];
    logic [AW-1:0] model_stack[$];
    logic [AW-1:0] model_pc;
    logic          model_ovf;
    logic          model_unf;
    int            n_asserts;
    int            n_fail;

    task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        n_asserts++;
        assert (scoreboard.size() > 0) else begin
            n_fail++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkField({e.tag, ".pc"}, 32'(pc), 32'(e.pc));
            checkField({e.tag, ".depth"}, 32'(depth), 32'(e.depth));
            checkField({e.tag, ".full"}, 32'(full), 32'(e.depth == DEPTH));
            checkField({e.tag, ".empty"}, 32'(empty), 32'(e.depth == 0));
            checkField({e.tag, ".ovf_err"}, 32'(ovf_err), 32'(e.ovf));
            checkField({e.tag, ".unf_err"}, 32'(unf_err), 32'(e.unf));
        end
    endtask

    // Drives one cycle of control, advances the reference model and checks the result
    task automatic applyStimulus(input string tag, input logic e_n, input logic [1:0] o,
                                 input logic r, input logic [AW-1:0] d, input logic c);
        logic [AW-1:0] seq_m;
        logic [AW-1:0] tgt_m;
        exp_t          e;
        en      = e_n;
        op      = o;
        rel     = r;
        din     = d;
        clr_err = c;
        seq_m = model_pc + AW'(STEP);
        tgt_m = r ? model_pc + d : d;
        if (c) begin
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end
        if (e_n) begin
            case (o)
                2'b00: model_pc = seq_m;
                2'b01: model_pc = tgt_m;
                2'b10: begin
                    model_stack.push_back(seq_m);
                    if (model_stack.size() > DEPTH) begin
                        void'(model_stack.pop_front());
                        model_ovf = 1'b1;
                    end
                    model_pc = tgt_m;
                end
                default: begin
                    if (model_stack.size() == 0) begin
                        model_pc  = seq_m;
                        model_unf = 1'b1;
                    end else begin
                        model_pc = model_stack.pop_back();
                    end
                end
            endcase
        end
        e.tag   = tag;
        e.pc    = model_pc;
        e.depth = model_stack.size();
        e.ovf   = model_ovf;
        e.unf   = model_unf;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        model_pc  = '0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        rst = 1'b1;
        en = 1'b0; op = 2'b00; rel = 1'b0; din = '0; clr_err = 1'b0;
        #2;
        checkField("reset.pc", 32'(pc), 32'h0);
        checkField("reset.depth", 32'(depth), 32'h0);
        checkField("reset.full", 32'(full), 32'h0);
        checkField("reset.empty", 32'(empty), 32'h1);
        checkField("reset.ovf_err", 32'(ovf_err), 32'h0);
        checkField("reset.unf_err", 32'(unf_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] step 1: sequential increment and hold");
        for (int i = 0; i < 4; i++) applyStimulus("inc", 1'b1, 2'b00, 1'b0, '0, 1'b0);
        checkField("inc4.pc_is_8", 32'(pc), 32'h8);
        for (int i = 0; i < 3; i++) applyStimulus("hold", 1'b0, 2'(i + 1), 1'b1, 10'h155, 1'b0);
        checkField("hold.pc_is_8", 32'(pc), 32'h8);

        $display("[TB] step 2: wrap-around and relative jump");
        applyStimulus("jmp_3fe", 1'b1, 2'b01, 1'b0, 10'h3FE, 1'b0);
        applyStimulus("inc_wrap", 1'b1, 2'b00, 1'b0, '0, 1'b0);
        checkField("wrap.pc_is_0", 32'(pc), 32'h0);
        applyStimulus("inc_2", 1'b1, 2'b00, 1'b0, '0, 1'b0);
        applyStimulus("jmp_rel_neg", 1'b1, 2'b01, 1'b1, 10'h3FC, 1'b0);
        checkField("jmp_rel.pc_is_3fe", 32'(pc), 32'h3FE);

        $display("[TB] step 3: nested calls");
        applyStimulus("jmp_010", 1'b1, 2'b01, 1'b0, 10'h010, 1'b0);
        applyStimulus("call_100", 1'b1, 2'b10, 1'b0, 10'h100, 1'b0);
        applyStimulus("call_200", 1'b1, 2'b10, 1'b0, 10'h200, 1'b0);
        applyStimulus("ret_1", 1'b1, 2'b11, 1'b0, '0, 1'b0);
        checkField("ret_1.pc_is_102", 32'(pc), 32'h102);
        applyStimulus("ret_2", 1'b1, 2'b11, 1'b0, '0, 1'b0);
        checkField("ret_2.pc_is_012", 32'(pc), 32'h012);
        applyStimulus("call_b2b", 1'b1, 2'b10, 1'b0, 10'h2A0, 1'b0);
        applyStimulus("ret_b2b", 1'b1, 2'b11, 1'b0, '0, 1'b0);
        checkField("ret_b2b.pc_is_014", 32'(pc), 32'h014);

        $display("[TB] step 4: stack overflow");
        applyStimulus("jmp_000", 1'b1, 2'b01, 1'b0, 10'h000, 1'b0);
        for (int i = 0; i < 17; i++) applyStimulus("call_fill", 1'b1, 2'b10, 1'b1, 10'h002, 1'b0);
        checkField("ovf.depth_16", 32'(depth), 32'd16);
        checkField("ovf.flag", 32'(ovf_err), 32'h1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus("ret_drain", 1'b1, 2'b11, 1'b0, '0, 1'b0);
            checkField("ret_drain.newest_first", 32'(pc), 32'(34 - 2 * i));
        end

        $display("[TB] step 5: underflow and error clearing");
        applyStimulus("clr_ovf_hold", 1'b0, 2'b10, 1'b0, 10'h123, 1'b1);
        applyStimulus("jmp_040", 1'b1, 2'b01, 1'b0, 10'h040, 1'b0);
        applyStimulus("ret_empty", 1'b1, 2'b11, 1'b0, '0, 1'b0);
        checkField("unf.pc_is_042", 32'(pc), 32'h042);
        applyStimulus("clr_unf", 1'b1, 2'b00, 1'b0, '0, 1'b1);
        applyStimulus("clr_and_unf", 1'b1, 2'b11, 1'b0, '0, 1'b1);
        checkField("clr_and_unf.set_wins", 32'(unf_err), 32'h1);

        $display("[TB] step 6: asynchronous reset mid-cycle");
        applyStimulus("clr_all", 1'b1, 2'b01, 1'b0, 10'h080, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus("call_pre_rst", 1'b1, 2'b10, 1'b1, 10'h010, 1'b0);
        en = 1'b1; op = 2'b10; rel = 1'b0; din = 10'h300; clr_err = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkField("async_rst.pc", 32'(pc), 32'h0);
        checkField("async_rst.depth", 32'(depth), 32'h0);
        checkField("async_rst.empty", 32'(empty), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_pc = '0;
        model_stack.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        applyStimulus("post_rst_inc", 1'b1, 2'b00, 1'b0, '0, 1'b0);
        applyStimulus("post_rst_ret", 1'b1, 2'b11, 1'b0, '0, 1'b0);

        checkField("scoreboard_drained", 32'(scoreboard.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
